sound_effect_sequencer: RTL and testbench

Sequencer and arbiter for the sine-table audio datapath. Accepts one-cycle sound-effect requests from game logic (player shot, invader hit, UFO), arbitrates them by fixed priority, and plays the selected effect as a four-note sequence. Each note is generated by a phase accumulator whose top bits drive the sine table address; the table's registered output goes on to the audio codec path.

---
 rtl/sound_effect_sequencer.sv | 248 ++++++++++++++++++++++++
 tb/tb_sound_effect_sequencer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/sound_effect_sequencer.sv
// ---------------------------------------------------------------------------
// sound_effect_sequencer
//
// Purpose: takes one-cycle sound-effect requests from game logic, arbitrates
// them by fixed priority (hit > shot > ufo) and plays the chosen effect as a
// four-note sequence.  Each note comes from a phase accumulator whose top bits
// address the downstream sine table.
//
// Ports:
//   clk       system clock
//   resetN    asynchronous active-low reset
//   shotReq   one-cycle pulse, requests the shot effect
//   hitReq    one-cycle pulse, requests the hit effect
//   ufoReq    one-cycle pulse, requests the UFO effect
//   sinAddr   registered sine table address (top COUNT_SIZE bits of phase)
//   soundEn   high while an effect plays
//   activeId  effect playing: 0 none, 1 shot, 2 hit, 3 ufo
//   noteIdx   index of the current note, 0..3
// ---------------------------------------------------------------------------
module sound_effect_sequencer #(
    parameter int COUNT_SIZE = 8,
    parameter int PHASE_W    = 24,
    parameter int TICK_DIV   = 50000,
    parameter int NOTE_TICKS = 60
) (
    input  logic                  clk,
    input  logic                  resetN,
    input  logic                  shotReq,
    input  logic                  hitReq,
    input  logic                  ufoReq,
    output logic [COUNT_SIZE-1:0] sinAddr,
    output logic                  soundEn,
    output logic [1:0]            activeId,
    output logic [1:0]            noteIdx
);

    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int TCK_W = (NOTE_TICKS > 1) ? $clog2(NOTE_TICKS) : 1;

    localparam logic [1:0] ID_NONE = 2'd0;
    localparam logic [1:0] ID_SHOT = 2'd1;
    localparam logic [1:0] ID_HIT  = 2'd2;
    localparam logic [1:0] ID_UFO  = 2'd3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PLAY = 1'b1
    } state_t;

    // Arbitration rank: larger wins.  Effect ids are not in priority order.
    function automatic logic [1:0] rank(input logic [1:0] id);
        logic [1:0] r;
        case (id)
            ID_HIT:  r = 2'd3;
            ID_SHOT: r = 2'd2;
            ID_UFO:  r = 2'd1;
            default: r = 2'd0;
        endcase
        return r;
    endfunction

    // Phase increment for a given effect and note.
    function automatic logic [PHASE_W-1:0] note_inc(input logic [1:0] id,
                                                    input logic [1:0] n);
        logic [PHASE_W-1:0] inc;
        case (id)
            ID_SHOT: begin
                case (n)
                    2'd0:    inc = PHASE_W'(10'd591);
                    2'd1:    inc = PHASE_W'(10'd443);
                    2'd2:    inc = PHASE_W'(10'd295);
                    default: inc = PHASE_W'(10'd148);
                endcase
            end
            ID_HIT: begin
                case (n)
                    2'd0:    inc = PHASE_W'(10'd74);
                    2'd1:    inc = PHASE_W'(10'd55);
                    2'd2:    inc = PHASE_W'(10'd37);
                    default: inc = PHASE_W'(10'd28);
                endcase
            end
            ID_UFO: begin
                case (n)
                    2'd0:    inc = PHASE_W'(10'd221);
                    2'd1:    inc = PHASE_W'(10'd295);
                    2'd2:    inc = PHASE_W'(10'd221);
                    default: inc = PHASE_W'(10'd295);
                endcase
            end
            default: inc = {PHASE_W{1'b0}};
        endcase
        return inc;
    endfunction

    state_t                 state_q, state_d;
    logic [3:1]             pend_q, pend_d;      // bit i = effect id i pending
    logic [1:0]             active_q, active_d;
    logic [1:0]             note_q, note_d;
    logic [PHASE_W-1:0]     phase_q, phase_d;
    logic [PRE_W-1:0]       presc_q, presc_d;
    logic [TCK_W-1:0]       tick_cnt_q, tick_cnt_d;
    logic [COUNT_SIZE-1:0]  sin_addr_q, sin_addr_d;
    logic                   sound_en_q, sound_en_d;

    logic [1:0]             sel_s;
    logic                   start_s;
    logic                   tick_s;
    logic                   note_end_s;
    logic [3:1]             clr_s;

    // Arbitration: pick the highest-priority pending effect and decide whether it starts.
    always_comb begin
        sel_s   = ID_NONE;
        start_s = 1'b0;
        if (pend_q[ID_HIT]) begin
            sel_s = ID_HIT;
        end else if (pend_q[ID_SHOT]) begin
            sel_s = ID_SHOT;
        end else if (pend_q[ID_UFO]) begin
            sel_s = ID_UFO;
        end else begin
            sel_s = ID_NONE;
        end
        // From IDLE anything pending starts; in PLAY only a strictly higher
        // rank preempts, so equal/lower requests wait for IDLE.
        if (sel_s == ID_NONE) begin
            start_s = 1'b0;
        end else if (state_q == ST_IDLE) begin
            start_s = 1'b1;
        end else begin
            start_s = (rank(sel_s) > rank(active_q));
        end
    end

    // Next-state, sequencing counters, pending latches and output staging.
    always_comb begin
        state_d    = state_q;
        active_d   = active_q;
        note_d     = note_q;
        phase_d    = phase_q;
        presc_d    = presc_q;
        tick_cnt_d = tick_cnt_q;

        tick_s     = (presc_q == PRE_W'(TICK_DIV - 1));
        note_end_s = tick_s && (tick_cnt_q == TCK_W'(NOTE_TICKS - 1));

        case (state_q)
            ST_IDLE: begin
                phase_d    = {PHASE_W{1'b0}};
                presc_d    = {PRE_W{1'b0}};
                tick_cnt_d = {TCK_W{1'b0}};
                note_d     = 2'd0;
                active_d   = ID_NONE;
                if (start_s) begin
                    state_d  = ST_PLAY;
                    active_d = sel_s;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_PLAY: begin
                if (start_s) begin
                    // Preemption outranks everything, including the final tick.
                    state_d    = ST_PLAY;
                    active_d   = sel_s;
                    note_d     = 2'd0;
                    phase_d    = {PHASE_W{1'b0}};
                    presc_d    = {PRE_W{1'b0}};
                    tick_cnt_d = {TCK_W{1'b0}};
                end else begin
                    phase_d = phase_q + note_inc(active_q, note_q);
                    if (tick_s) begin
                        presc_d = {PRE_W{1'b0}};
                        if (note_end_s) begin
                            tick_cnt_d = {TCK_W{1'b0}};
                            if (note_q == 2'd3) begin
                                state_d  = ST_IDLE;
                                active_d = ID_NONE;
                                note_d   = 2'd0;
                                phase_d  = {PHASE_W{1'b0}};
                            end else begin
                                note_d   = note_q + 2'd1;
                            end
                        end else begin
                            tick_cnt_d = tick_cnt_q + TCK_W'(1'b1);
                        end
                    end else begin
                        presc_d = presc_q + PRE_W'(1'b1);
                    end
                end
            end
            default: begin
                state_d    = ST_IDLE;
                active_d   = ID_NONE;
                note_d     = 2'd0;
                phase_d    = {PHASE_W{1'b0}};
                presc_d    = {PRE_W{1'b0}};
                tick_cnt_d = {TCK_W{1'b0}};
            end
        endcase

        // A latch clears when its effect starts; a new pulse on the same edge wins.
        clr_s[ID_SHOT] = start_s && (sel_s == ID_SHOT);
        clr_s[ID_HIT]  = start_s && (sel_s == ID_HIT);
        clr_s[ID_UFO]  = start_s && (sel_s == ID_UFO);
        pend_d = (pend_q & ~clr_s) | {ufoReq, hitReq, shotReq};

        // Address follows the pre-edge phase; forced to 0 whenever we will be idle.
        if (state_d == ST_PLAY) begin
            sin_addr_d = phase_q[PHASE_W-1 -: COUNT_SIZE];
        end else begin
            sin_addr_d = {COUNT_SIZE{1'b0}};
        end
        sound_en_d = (state_d == ST_PLAY);
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q    <= ST_IDLE;
            pend_q     <= 3'b000;
            active_q   <= ID_NONE;
            note_q     <= 2'd0;
            phase_q    <= {PHASE_W{1'b0}};
            presc_q    <= {PRE_W{1'b0}};
            tick_cnt_q <= {TCK_W{1'b0}};
            sin_addr_q <= {COUNT_SIZE{1'b0}};
            sound_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            active_q   <= active_d;
            note_q     <= note_d;
            phase_q    <= phase_d;
            presc_q    <= presc_d;
            tick_cnt_q <= tick_cnt_d;
            sin_addr_q <= sin_addr_d;
            sound_en_q <= sound_en_d;
        end
    end

    assign sinAddr  = sin_addr_q;
    assign soundEn  = sound_en_q;
    assign activeId = active_q;
    assign noteIdx  = note_q;

endmodule

// File: tb/tb_sound_effect_sequencer.sv
// ---------------------------------------------------------------------------
// Directed testbench for sound_effect_sequencer.
// TICK_DIV = 4, NOTE_TICKS = 2 -> 8 clocks per note, 32 per effect.
// PHASE_W = 12 so that sinAddr = phase >> 4 moves visibly within a note.
// Inputs are driven and outputs sampled at the falling clock edge.
// ---------------------------------------------------------------------------
module tb_sound_effect_sequencer;

    logic       clk = 1'b0;
    logic       resetN;
    logic       shotReq;
    logic       hitReq;
    logic       ufoReq;
    logic [7:0] sinAddr;
    logic       soundEn;
    logic [1:0] activeId;
    logic [1:0] noteIdx;

    int n_tests = 0;
    int n_fail  = 0;

    // sinAddr after start edge S + k, k = 1..10, for the shot effect:
    // phase after S+j = 591*j for j <= 8 (mod 4096), then +443 per clock.
    int exp_shot [10] = '{0, 36, 73, 110, 147, 184, 221, 2, 39, 67};

    sound_effect_sequencer #(
        .COUNT_SIZE (8),
        .PHASE_W    (12),
        .TICK_DIV   (4),
        .NOTE_TICKS (2)
    ) dut (
        .clk      (clk),
        .resetN   (resetN),
        .shotReq  (shotReq),
        .hitReq   (hitReq),
        .ufoReq   (ufoReq),
        .sinAddr  (sinAddr),
        .soundEn  (soundEn),
        .activeId (activeId),
        .noteIdx  (noteIdx)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        resetN  = 1'b0;
        shotReq = 1'b0;
        hitReq  = 1'b0;
        ufoReq  = 1'b0;
        step(2);
        check_eq("rst_sinAddr",  32'(sinAddr),  32'd0);
        check_eq("rst_soundEn",  32'(soundEn),  32'd0);
        check_eq("rst_activeId", 32'(activeId), 32'd0);
        check_eq("rst_noteIdx",  32'(noteIdx),  32'd0);
        resetN = 1'b1;
        step(1);

        // ---- single shot ----
        shotReq = 1'b1;
        step(1);
        shotReq = 1'b0;
        check_eq("shot_latency_en", 32'(soundEn), 32'd0);
        step(1);
        check_eq("shot_start_en",   32'(soundEn),  32'd1);
        check_eq("shot_start_id",   32'(activeId), 32'd1);
        check_eq("shot_start_note", 32'(noteIdx),  32'd0);
        for (int k = 1; k <= 33; k++) begin
            step(1);
            check_eq($sformatf("shot_en_k%0d", k), 32'(soundEn), (k < 32) ? 32'd1 : 32'd0);
            check_eq($sformatf("shot_note_k%0d", k), 32'(noteIdx), (k < 32) ? 32'(k / 8) : 32'd0);
            if (k <= 10) begin
                check_eq($sformatf("shot_addr_k%0d", k), 32'(sinAddr), 32'(exp_shot[k-1]));
            end
            if (k >= 32) begin
                check_eq($sformatf("shot_idle_id_k%0d", k), 32'(activeId), 32'd0);
                check_eq($sformatf("shot_idle_addr_k%0d", k), 32'(sinAddr), 32'd0);
            end
        end

        // ---- priority: shot and ufo together, then preemption by hit ----
        shotReq = 1'b1;
        ufoReq  = 1'b1;
        step(1);
        shotReq = 1'b0;
        ufoReq  = 1'b0;
        step(1);
        check_eq("prio_first_id", 32'(activeId), 32'd1);
        step(31);
        check_eq("prio_shot_last_id", 32'(activeId), 32'd1);
        step(1);
        check_eq("prio_gap_en", 32'(soundEn), 32'd0);
        step(1);
        check_eq("prio_ufo_id",   32'(activeId), 32'd3);
        check_eq("prio_ufo_en",   32'(soundEn),  32'd1);
        check_eq("prio_ufo_note", 32'(noteIdx),  32'd0);
        step(2);
        check_eq("ufo_addr_k2", 32'(sinAddr), 32'd13);
        step(6);
        check_eq("ufo_note1", 32'(noteIdx), 32'd1);
        step(1);
        check_eq("ufo_addr_k9", 32'(sinAddr), 32'd110);
        step(1);
        check_eq("ufo_addr_k10", 32'(sinAddr), 32'd128);
        hitReq = 1'b1;
        step(1);
        hitReq = 1'b0;
        check_eq("pre_latch_id", 32'(activeId), 32'd3);
        step(1);
        check_eq("pre_hit_id",   32'(activeId), 32'd2);
        check_eq("pre_hit_note", 32'(noteIdx),  32'd0);
        check_eq("pre_hit_en",   32'(soundEn),  32'd1);
        step(1);
        check_eq("pre_hit_addr1", 32'(sinAddr), 32'd0);
        step(1);
        check_eq("pre_hit_addr2", 32'(sinAddr), 32'd4);
        step(30);
        check_eq("pre_hit_end_en", 32'(soundEn), 32'd0);
        step(1);
        check_eq("pre_no_resume_en", 32'(soundEn),  32'd0);
        check_eq("pre_no_resume_id", 32'(activeId), 32'd0);
        step(3);
        check_eq("pre_no_resume_en2", 32'(soundEn), 32'd0);

        // ---- lower priority does not preempt ----
        hitReq = 1'b1;
        step(1);
        hitReq = 1'b0;
        step(1);
        check_eq("lo_hit_id", 32'(activeId), 32'd2);
        step(5);
        shotReq = 1'b1;
        step(1);
        shotReq = 1'b0;
        check_eq("lo_keep_id",   32'(activeId), 32'd2);
        check_eq("lo_keep_note", 32'(noteIdx),  32'd0);
        step(10);
        check_eq("lo_note2_id",  32'(activeId), 32'd2);
        check_eq("lo_note2",     32'(noteIdx),  32'd2);
        step(16);
        check_eq("lo_gap_en", 32'(soundEn), 32'd0);
        step(1);
        check_eq("lo_shot_id", 32'(activeId), 32'd1);
        check_eq("lo_shot_en", 32'(soundEn),  32'd1);
        step(32);
        check_eq("lo_shot_end_en", 32'(soundEn), 32'd0);
        step(2);

        // ---- re-trigger: request held across the start edge ----
        shotReq = 1'b1;
        step(1);
        step(1);
        shotReq = 1'b0;
        check_eq("rt_first_id", 32'(activeId), 32'd1);
        step(32);
        check_eq("rt_gap_en", 32'(soundEn), 32'd0);
        step(1);
        check_eq("rt_second_en",   32'(soundEn),  32'd1);
        check_eq("rt_second_id",   32'(activeId), 32'd1);
        check_eq("rt_second_note", 32'(noteIdx),  32'd0);
        step(31);
        check_eq("rt_second_last_note", 32'(noteIdx), 32'd3);
        step(1);
        check_eq("rt_done_en", 32'(soundEn), 32'd0);
        step(2);
        check_eq("rt_no_third_en", 32'(soundEn), 32'd0);

        // ---- reset mid-effect ----
        shotReq = 1'b1;
        step(1);
        shotReq = 1'b0;
        step(1);
        step(18);
        check_eq("rst_mid_note2", 32'(noteIdx), 32'd2);
        #2 resetN = 1'b0;
        #1;
        check_eq("rst_mid_en",   32'(soundEn),  32'd0);
        check_eq("rst_mid_id",   32'(activeId), 32'd0);
        check_eq("rst_mid_note", 32'(noteIdx),  32'd0);
        check_eq("rst_mid_addr", 32'(sinAddr),  32'd0);
        shotReq = 1'b1;
        step(2);
        shotReq = 1'b0;
        resetN  = 1'b1;
        step(4);
        check_eq("rst_after_en", 32'(soundEn),  32'd0);
        check_eq("rst_after_id", 32'(activeId), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
